// File: rtl/int_bus_regfile_if.sv
// Bus-side signals between a bus master and the int_bus_regfile register block.
interface int_bus_regfile_if;
  logic [15:0] int_address;
  logic [7:0]  int_wr_data;
  logic        int_write;
  logic        int_read;
  logic [7:0]  int_rd_data;
  logic        int_req;
  logic        int_gnt;

  modport master (
    output int_address, int_wr_data, int_write, int_read, int_req,
    input  int_rd_data, int_gnt
  );

  modport slave (
    input  int_address, int_wr_data, int_write, int_read, int_req,
    output int_rd_data, int_gnt
  );
endinterface

// File: rtl/int_bus_regfile.sv
// Granted-bus register file: ID/SCRATCH/CTRL/STATUS/EVENT/EVENT_MASK/ERR_CNT, one-cycle access.
// Optional macro INT_BUS_ERR_CNT_EN builds the saturating ERR_CNT counter at offset 0x6.
module int_bus_regfile #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [7:0]  ID_VALUE  = 8'hA5
) (
  input  logic                 clock,
  input  logic                 reset,
  int_bus_regfile_if.slave     bus,
  input  logic                 local_busy,
  input  logic [7:0]           status_in,
  input  logic [7:0]           event_in,
  output logic [7:0]           ctrl_out,
  output logic                 irq
);

  typedef enum logic [1:0] {IDLE, GRANTED, RELEASE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_gnt;
  logic        w_hit;
  logic        w_acc_wr;
  logic        w_acc_rd;
  logic [3:0]  w_off;
  logic [7:0]  w_rd_mux;
  logic [7:0]  w_err_cnt;
  logic [7:0]  r_rd_data;
  logic [7:0]  r_scratch;
  logic [7:0]  r_ctrl;
  logic [7:0]  r_event;
  logic [7:0]  r_mask;
  logic        r_irq;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.int_req && !local_busy) w_state_nxt = GRANTED;
      GRANTED: if (!bus.int_req)               w_state_nxt = RELEASE;
      RELEASE:                                 w_state_nxt = IDLE;
      default:                                 w_state_nxt = IDLE;
    endcase
  end

  assign w_gnt    = (r_state == GRANTED);
  assign w_hit    = (bus.int_address[15:4] == BASE_ADDR[15:4]);
  assign w_off    = bus.int_address[3:0];
  assign w_acc_wr = bus.int_write & w_gnt & w_hit;
  assign w_acc_rd = bus.int_read  & w_gnt & w_hit;

  // Read mux sees pre-write register values, so a simultaneous write/read returns old data.
  always_comb begin
    w_rd_mux = 8'h00;
    case (w_off)
      4'h0:    w_rd_mux = ID_VALUE;
      4'h1:    w_rd_mux = r_scratch;
      4'h2:    w_rd_mux = r_ctrl;
      4'h3:    w_rd_mux = status_in;
      4'h4:    w_rd_mux = r_event;
      4'h5:    w_rd_mux = r_mask;
      4'h6:    w_rd_mux = w_err_cnt;
      default: w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_data <= 8'h00;
      r_scratch <= 8'h00;
      r_ctrl    <= 8'h00;
      r_event   <= 8'h00;
      r_mask    <= 8'h00;
      r_irq     <= 1'b0;
    end else begin
      if (w_acc_rd)                  r_rd_data <= w_rd_mux;
      if (w_acc_wr && w_off == 4'h1) r_scratch <= bus.int_wr_data;
      if (w_acc_wr && w_off == 4'h2) r_ctrl    <= bus.int_wr_data;
      if (w_acc_wr && w_off == 4'h5) r_mask    <= bus.int_wr_data;
      // New events are OR-ed in after the W1C so a same-cycle set wins.
      r_event <= (r_event & ~((w_acc_wr && w_off == 4'h4) ? bus.int_wr_data : 8'h00)) | event_in;
      r_irq   <= |(r_event & r_mask);
    end
  end

`ifdef INT_BUS_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  logic       w_err;

  assign w_err = (bus.int_write | bus.int_read) & ~(w_gnt & w_hit);

  always_ff @(posedge clock) begin
    if (reset)                                r_err_cnt <= 8'h00;
    else if (w_acc_wr && w_off == 4'h6)       r_err_cnt <= 8'h00;
    else if (w_err && r_err_cnt != 8'hFF)     r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign w_err_cnt = r_err_cnt;
`else
  assign w_err_cnt = 8'h00;
`endif

  assign bus.int_gnt     = w_gnt;
  assign bus.int_rd_data = r_rd_data;
  assign ctrl_out        = r_ctrl;
  assign irq             = r_irq;

endmodule

// File: tb/tb_int_bus_regfile.sv
// Random + directed bench for int_bus_regfile against a cycle-level behavioural model.
module tb_int_bus_regfile;

  localparam logic [15:0] BASE = 16'h0000;
  localparam logic [7:0]  IDV  = 8'hA5;

  logic       clock = 1'b0;
  logic       reset;
  logic       local_busy;
  logic [7:0] status_in;
  logic [7:0] event_in;
  logic [7:0] ctrl_out;
  logic       irq;

  int n_chk = 0;
  int n_bad = 0;

  int_bus_regfile_if bus();

  int_bus_regfile #(.BASE_ADDR(BASE), .ID_VALUE(IDV)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .local_busy (local_busy),
    .status_in  (status_in),
    .event_in   (event_in),
    .ctrl_out   (ctrl_out),
    .irq        (irq)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic       m_gnt, m_cool, m_irq;
  logic [7:0] m_scratch, m_ctrl, m_event, m_mask, m_err, m_rd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_reg(input logic [3:0] off, input logic [7:0] st);
    case (off)
      4'h0: return IDV;
      4'h1: return m_scratch;
      4'h2: return m_ctrl;
      4'h3: return st;
      4'h4: return m_event;
      4'h5: return m_mask;
`ifdef INT_BUS_ERR_CNT_EN
      4'h6: return m_err;
`endif
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step(input logic rst, input logic req, input logic busy,
                            input logic [15:0] addr, input logic [7:0] wd,
                            input logic wr, input logic rd, input logic [7:0] ev,
                            input logic [7:0] st);
    logic       acc;
    logic [3:0] off;
    logic [7:0] n_event;
    logic       n_irq;
    if (rst) begin
      m_gnt = 0; m_cool = 0; m_irq = 0;
      m_scratch = 0; m_ctrl = 0; m_event = 0; m_mask = 0; m_err = 0; m_rd = 0;
      return;
    end
    acc     = m_gnt && (addr[15:4] == BASE[15:4]);
    off     = addr[3:0];
    n_event = m_event;
    n_irq   = |(m_event & m_mask);
    if (rd && acc) m_rd = m_reg(off, st);
    if (wr && acc) begin
      if (off == 4'h1) m_scratch = wd;
      if (off == 4'h2) m_ctrl    = wd;
      if (off == 4'h4) n_event   = n_event & ~wd;
      if (off == 4'h5) m_mask    = wd;
      if (off == 4'h6) m_err     = 8'h00;
    end
`ifdef INT_BUS_ERR_CNT_EN
    if ((wr || rd) && !acc && m_err != 8'hFF) m_err = m_err + 8'd1;
`endif
    m_event = n_event | ev;
    m_irq   = n_irq;
    // Grant: one dead cycle after each release.
    if (m_cool)          begin m_gnt = 0; m_cool = 0; end
    else if (m_gnt)      begin if (!req) begin m_gnt = 0; m_cool = 1; end end
    else if (req && !busy) m_gnt = 1;
  endtask

  task automatic cyc(input logic rst, input logic req, input logic busy,
                     input logic [15:0] addr, input logic [7:0] wd,
                     input logic wr, input logic rd, input logic [7:0] ev);
    logic [7:0] st;
    st              = 8'($urandom);
    reset           = rst;
    local_busy      = busy;
    status_in       = st;
    event_in        = ev;
    bus.int_req     = req;
    bus.int_address = addr;
    bus.int_wr_data = wd;
    bus.int_write   = wr;
    bus.int_read    = rd;
    model_step(rst, req, busy, addr, wd, wr, rd, ev, st);
    @(posedge clock);
    #1;
    check_val("gnt",  bus.int_gnt,     m_gnt);
    check_val("rd",   bus.int_rd_data, m_rd);
    check_val("ctrl", ctrl_out,        m_ctrl);
    check_val("irq",  irq,             m_irq);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  ev;
    // Reset state
    cyc(1, 0, 0, 16'h0, 8'h00, 0, 0, 8'h00);
    check_val("rst_gnt", bus.int_gnt, 1'b0);
    check_val("rst_rd", bus.int_rd_data, 8'h00);

    // Grant timing and the dead cycle after release
    cyc(0, 1, 0, 16'h0, 8'h00, 0, 0, 8'h00);
    check_val("gnt_c1", bus.int_gnt, 1'b1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 16'h0, 8'h00, 0, 0, 8'h00);
    check_val("gnt_busy_hold", bus.int_gnt, 1'b1);
    cyc(0, 0, 0, 16'h0, 8'h00, 0, 0, 8'h00);
    check_val("gnt_c6", bus.int_gnt, 1'b0);
    cyc(0, 1, 0, 16'h0, 8'h00, 0, 0, 8'h00);
    check_val("gnt_c7_dead", bus.int_gnt, 1'b0);
    cyc(0, 1, 0, 16'h0, 8'h00, 0, 0, 8'h00);
    check_val("gnt_c8", bus.int_gnt, 1'b1);

    // CTRL write/read and ID
    cyc(0, 1, 0, 16'h0002, 8'h3C, 1, 0, 8'h00);
    check_val("ctrl_3c", ctrl_out, 8'h3C);
    cyc(0, 1, 0, 16'h0002, 8'h00, 0, 1, 8'h00);
    check_val("rd_ctrl", bus.int_rd_data, 8'h3C);
    cyc(0, 1, 0, 16'h0000, 8'h00, 0, 1, 8'h00);
    check_val("rd_id", bus.int_rd_data, 8'hA5);
    cyc(0, 1, 0, 16'h0001, 8'h99, 1, 1, 8'h00);
    check_val("wr_rd_old", bus.int_rd_data, 8'h00);

    // EVENT / irq
    cyc(0, 1, 0, 16'h0005, 8'h04, 1, 0, 8'h00);
    cyc(0, 1, 0, 16'h0000, 8'h00, 0, 0, 8'h05);
    check_val("irq_c1", irq, 1'b0);
    cyc(0, 1, 0, 16'h0000, 8'h00, 0, 0, 8'h00);
    check_val("irq_c2", irq, 1'b1);
    cyc(0, 1, 0, 16'h0004, 8'h04, 1, 0, 8'h04);
    cyc(0, 1, 0, 16'h0004, 8'h00, 0, 1, 8'h00);
    check_val("event_set_wins", bus.int_rd_data, 8'h05);
    cyc(0, 1, 0, 16'h0004, 8'h05, 1, 0, 8'h00);
    cyc(0, 1, 0, 16'h0004, 8'h00, 0, 1, 8'h00);
    check_val("event_clr", bus.int_rd_data, 8'h00);
    check_val("irq_clr", irq, 1'b0);

    // Busy blocks grant; ungranted write ignored and counted
    cyc(0, 0, 0, 16'h0, 8'h00, 0, 0, 8'h00);
    cyc(0, 0, 0, 16'h0, 8'h00, 0, 0, 8'h00);
    cyc(0, 1, 1, 16'h0, 8'h00, 0, 0, 8'h00);
    check_val("busy_nogrant", bus.int_gnt, 1'b0);
    cyc(0, 1, 1, 16'h0001, 8'h77, 1, 0, 8'h00);
    check_val("busy_nogrant2", bus.int_gnt, 1'b0);
    cyc(0, 1, 0, 16'h0, 8'h00, 0, 0, 8'h00);
    cyc(0, 1, 0, 16'h0001, 8'h00, 0, 1, 8'h00);
    check_val("scratch_kept", bus.int_rd_data, 8'h99);
    cyc(0, 1, 0, 16'h0006, 8'h00, 0, 1, 8'h00);
`ifdef INT_BUS_ERR_CNT_EN
    check_val("err_cnt", bus.int_rd_data, 8'h01);
`else
    check_val("err_cnt", bus.int_rd_data, 8'h00);
`endif

    // Reset mid-grant
    cyc(0, 1, 0, 16'h0002, 8'hFF, 1, 0, 8'h00);
    check_val("ctrl_ff", ctrl_out, 8'hFF);
    cyc(0, 1, 0, 16'h0000, 8'h00, 0, 1, 8'h00);
    cyc(1, 1, 0, 16'h0002, 8'h11, 1, 1, 8'h00);
    check_val("rst_mid_gnt", bus.int_gnt, 1'b0);
    check_val("rst_mid_ctrl", ctrl_out, 8'h00);
    check_val("rst_mid_rd", bus.int_rd_data, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      a  = {(($urandom_range(0, 3) == 0) ? 12'($urandom) : BASE[15:4]), 4'($urandom)};
      ev = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
          a, 8'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ev);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
